// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM pipeline register built as a 2-entry skid buffer
//            (main output register plus skid register), valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic [DATA_WIDTH-1:0]     aluResult_in,
    input  logic                      zeroFlag_in,
    input  logic [DATA_WIDTH-1:0]     storeData_in,
    input  logic [DATA_WIDTH-1:0]     branchTarget_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    input  logic [3:0]                ctrl_in,
    input  logic                      flush_in,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [DATA_WIDTH-1:0]     aluResult_out,
    output logic [DATA_WIDTH-1:0]     storeData_out,
    output logic [DATA_WIDTH-1:0]     branchTarget_out,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic [2:0]                ctrl_out,
    output logic                      branchTaken_out
);

    // Entry layout, MSB first: {taken, ctrl[2:0], rd, branchTarget, storeData, aluResult}
    localparam int ENTRY_W = 3 * DATA_WIDTH + REG_ADDR_WIDTH + 4;

    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] main_entry;
    logic [ENTRY_W-1:0] skid_entry;
    logic               main_valid;
    logic               skid_valid;
    logic               accept;
    logic               transfer;

    assign in_entry = {ctrl_in[3] & zeroFlag_in, ctrl_in[2:0], rd_in,
                       branchTarget_in, storeData_in, aluResult_in};

    assign ready_out = ~skid_valid & ~reset_in;
    assign accept    = valid_in & ready_out & ~flush_in;
    assign transfer  = main_valid & ready_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_entry <= '0;
            skid_entry <= '0;
        end else if (flush_in) begin
            // Data flops keep their contents so the outputs hold after a flush.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || transfer) begin
            if (skid_valid) begin
                main_entry <= skid_entry;
                main_valid <= 1'b1;
                if (accept) begin
                    skid_entry <= in_entry;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (accept) begin
                main_entry <= in_entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_entry <= in_entry;
            skid_valid <= 1'b1;
        end
    end

    assign valid_out        = main_valid;
    assign aluResult_out    = main_entry[DATA_WIDTH-1:0];
    assign storeData_out    = main_entry[2*DATA_WIDTH-1:DATA_WIDTH];
    assign branchTarget_out = main_entry[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign rd_out           = main_entry[3*DATA_WIDTH+REG_ADDR_WIDTH-1:3*DATA_WIDTH];
    assign ctrl_out         = main_entry[ENTRY_W-2:ENTRY_W-4];
    assign branchTaken_out  = main_valid & main_entry[ENTRY_W-1];

endmodule

`default_nettype wire
